// File: rtl/ddr_rr_arbiter_if.sv
// Bus bundle for ddr_rr_arbiter: four requester channels plus the shared DDRAM command/data port.
// master is the arbiter's view, slave is the view of the surrounding requesters and memory.
interface ddr_rr_arbiter_if #(
    parameter int DATA_W = 64
);
    logic [3:0]                 ch_req;
    logic [3:0]                 ch_we;
    logic [3:0][28:0]           ch_addr;
    logic [3:0][3:0]            ch_burst;
    logic [3:0][DATA_W-1:0]     ch_din;
    logic [3:0][DATA_W/8-1:0]   ch_be;
    logic [3:0]                 ch_ack;
    logic [3:0]                 ch_rvalid;
    logic [DATA_W-1:0]          rdata;

    logic                       DDRAM_BUSY;
    logic [DATA_W-1:0]          DDRAM_DOUT;
    logic                       DDRAM_DOUT_READY;
    logic [28:0]                DDRAM_ADDR;
    logic [7:0]                 DDRAM_BURSTCNT;
    logic [DATA_W-1:0]          DDRAM_DIN;
    logic [DATA_W/8-1:0]        DDRAM_BE;
    logic                       DDRAM_RD;
    logic                       DDRAM_WE;

    modport master (
        input  ch_req, ch_we, ch_addr, ch_burst, ch_din, ch_be,
        output ch_ack, ch_rvalid, rdata,
        input  DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        output DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_DIN, DDRAM_BE, DDRAM_RD, DDRAM_WE
    );

    modport slave (
        output ch_req, ch_we, ch_addr, ch_burst, ch_din, ch_be,
        input  ch_ack, ch_rvalid, rdata,
        output DDRAM_BUSY, DDRAM_DOUT, DDRAM_DOUT_READY,
        input  DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_DIN, DDRAM_BE, DDRAM_RD, DDRAM_WE
    );
endinterface

// File: rtl/ddr_rr_arbiter.sv
// Four-channel round-robin arbiter onto a single DDRAM port: one outstanding command at a time,
// writes are single-beat, reads return 1..8 beats routed to the granted channel.
module ddr_rr_arbiter #(
    parameter int DATA_W = 64
) (
    input  logic               clk,
    input  logic               rst,
    ddr_rr_arbiter_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [1:0]             last;
    logic [3:0]             beat_cnt;

    logic [1:0]             owner;
    logic                   cmd_we;
    logic [28:0]            cmd_addr;
    logic [3:0]             cmd_burst;
    logic [DATA_W-1:0]      cmd_din;
    logic [DATA_W/8-1:0]    cmd_be;

    logic                   any_req;
    logic [1:0]             winner;
    logic                   grant;
    logic                   accept;
    logic                   last_beat;

    // Beat counts outside 1..8 are clamped so the DDRAM never sees an illegal burst.
    function automatic logic [3:0] sat_burst(input logic [3:0] b);
        if (b == 4'd0)
            return 4'd1;
        if (b > 4'd8)
            return 4'd8;
        return b;
    endfunction

    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign any_req   = |bus.ch_req;
    assign winner    = rr_pick(bus.ch_req, last);
    assign grant     = (state == IDLE) && any_req;
    assign accept    = (state == ISSUE) && !bus.DDRAM_BUSY;
    assign last_beat = (state == RDWAIT) && bus.DDRAM_DOUT_READY &&
                       (beat_cnt == cmd_burst - 4'd1);

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   if (!bus.DDRAM_BUSY) state_nxt = cmd_we ? IDLE : RDWAIT;
            RDWAIT:  if (last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control: round-robin pointer and beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= 2'd3;
            beat_cnt <= '0;
        end else begin
            if (grant)
                last <= winner;
            if (accept)
                beat_cnt <= '0;
            else if ((state == RDWAIT) && bus.DDRAM_DOUT_READY)
                beat_cnt <= beat_cnt + 4'd1;
        end
    end

    // Command capture: the winner's request is frozen here for the whole transaction
    always_ff @(posedge clk) begin
        if (grant) begin
            owner     <= winner;
            cmd_we    <= bus.ch_we[winner];
            cmd_addr  <= bus.ch_addr[winner];
            cmd_burst <= sat_burst(bus.ch_burst[winner]);
            cmd_din   <= bus.ch_din[winner];
            cmd_be    <= bus.ch_be[winner];
        end
    end

    assign bus.DDRAM_ADDR = cmd_addr;
    assign bus.DDRAM_DIN  = cmd_din;
    assign bus.rdata      = bus.DDRAM_DOUT;

    // Outputs are gated by rst so reset values hold for the whole time rst is high.
    always_comb begin
        bus.DDRAM_RD       = 1'b0;
        bus.DDRAM_WE       = 1'b0;
        bus.DDRAM_BURSTCNT = 8'd0;
        bus.DDRAM_BE       = '0;
        bus.ch_ack         = 4'b0;
        bus.ch_rvalid      = 4'b0;
        if (!rst) begin
            case (state)
                ISSUE: begin
                    bus.DDRAM_RD       = !cmd_we;
                    bus.DDRAM_WE       = cmd_we;
                    bus.DDRAM_BURSTCNT = cmd_we ? 8'd1 : {4'b0, cmd_burst};
                    bus.DDRAM_BE       = cmd_we ? cmd_be : '1;
                    if (!bus.DDRAM_BUSY && cmd_we)
                        bus.ch_ack[owner] = 1'b1;
                end
                RDWAIT: begin
                    bus.ch_rvalid[owner] = bus.DDRAM_DOUT_READY;
                    if (last_beat)
                        bus.ch_ack[owner] = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_rr_arbiter.sv
// Bench for ddr_rr_arbiter: directed scenarios then random traffic, checked against a
// transaction-level model (round-robin search, burst clamp, beat scoreboard).
module tb_ddr_rr_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    int          m_last;
    logic        m_we    [4];
    logic [28:0] m_addr  [4];
    logic [3:0]  m_burst [4];
    logic [63:0] m_din   [4];
    logic [7:0]  m_be    [4];
    logic [28:0] issued_addr;
    int          w;

    ddr_rr_arbiter_if bus ();

    ddr_rr_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_beats(input logic [3:0] b);
        int n;
        n = int'(b);
        if (n < 1) n = 1;
        if (n > 8) n = 8;
        return n;
    endfunction

    task automatic set_ch(input int c, input logic we, input logic [28:0] a,
                          input logic [3:0] b, input logic [7:0] be);
        m_we[c]    = we;
        m_addr[c]  = a;
        m_burst[c] = b;
        m_din[c]   = {$urandom, $urandom};
        m_be[c]    = be;
        bus.ch_we[c]    = we;
        bus.ch_addr[c]  = a;
        bus.ch_burst[c] = b;
        bus.ch_din[c]   = m_din[c];
        bus.ch_be[c]    = be;
        bus.ch_req[c]   = 1'b1;
    endtask

    // Called inside an IDLE cycle with at least one request pending.
    task automatic run_txn(input int busy_n, input int max_gap, input int abort_at, output int win);
        int          n;
        int          g;
        logic [63:0] d;
        logic [3:0]  one;
        win = -1;
        for (int k = 1; k <= 4; k++)
            if (win < 0 && bus.ch_req[(m_last + k) % 4]) win = (m_last + k) % 4;
        if (win < 0) win = 0;
        one = 4'(1 << win);
        n   = m_we[win] ? 1 : exp_beats(m_burst[win]);
        chk("idle_cmd", 64'({bus.DDRAM_RD, bus.DDRAM_WE}), 64'(0));
        tick();
        issued_addr = bus.DDRAM_ADDR;
        for (int i = 0; i <= busy_n; i++) begin
            bus.DDRAM_BUSY       = (i < busy_n);
            bus.DDRAM_DOUT_READY = 1'($urandom_range(0, 1));
            #1;
            chk("issue_rd", 64'(bus.DDRAM_RD), 64'(!m_we[win]));
            chk("issue_we", 64'(bus.DDRAM_WE), 64'(m_we[win]));
            chk("issue_addr", 64'(bus.DDRAM_ADDR), 64'(m_addr[win]));
            chk("issue_bcnt", 64'(bus.DDRAM_BURSTCNT), 64'(n));
            chk("issue_be", 64'(bus.DDRAM_BE), 64'(m_we[win] ? m_be[win] : 8'hFF));
            if (m_we[win]) chk("issue_din", bus.DDRAM_DIN, m_din[win]);
            chk("issue_ack", 64'(bus.ch_ack), 64'((i == busy_n && m_we[win]) ? one : 4'b0));
            chk("issue_rvalid", 64'(bus.ch_rvalid), 64'(0));
            tick();
        end
        bus.DDRAM_BUSY       = 1'b0;
        bus.DDRAM_DOUT_READY = 1'b0;
        m_last = win;
        if (!m_we[win]) begin
            for (int k = 0; k < n; k++) begin
                if (k == abort_at) begin
                    rst = 1'b1;
                    bus.DDRAM_DOUT_READY = 1'b1;
                    bus.ch_req[win] = 1'b0;
                    #1;
                    chk("rst_ack", 64'(bus.ch_ack), 64'(0));
                    chk("rst_rvalid", 64'(bus.ch_rvalid), 64'(0));
                    chk("rst_cmd", 64'({bus.DDRAM_RD, bus.DDRAM_WE}), 64'(0));
                    chk("rst_bcnt", 64'(bus.DDRAM_BURSTCNT), 64'(0));
                    chk("rst_be", 64'(bus.DDRAM_BE), 64'(0));
                    tick();
                    rst = 1'b0;
                    m_last = 3;
                    for (int j = k; j < n; j++) begin
                        bus.DDRAM_DOUT = {$urandom, $urandom};
                        bus.DDRAM_DOUT_READY = 1'b1;
                        #1;
                        chk("late_rvalid", 64'(bus.ch_rvalid), 64'(0));
                        chk("late_ack", 64'(bus.ch_ack), 64'(0));
                        chk("late_cmd", 64'({bus.DDRAM_RD, bus.DDRAM_WE}), 64'(0));
                        tick();
                    end
                    bus.DDRAM_DOUT_READY = 1'b0;
                    return;
                end
                g = $urandom_range(0, max_gap);
                for (int q = 0; q < g; q++) begin
                    bus.DDRAM_DOUT_READY = 1'b0;
                    #1;
                    chk("gap_rvalid", 64'(bus.ch_rvalid), 64'(0));
                    chk("gap_ack", 64'(bus.ch_ack), 64'(0));
                    tick();
                end
                d = {$urandom, $urandom};
                bus.DDRAM_DOUT       = d;
                bus.DDRAM_DOUT_READY = 1'b1;
                #1;
                chk("beat_rvalid", 64'(bus.ch_rvalid), 64'(one));
                chk("beat_rdata", bus.rdata, d);
                chk("beat_ack", 64'(bus.ch_ack), 64'((k == n - 1) ? one : 4'b0));
                chk("beat_cmd", 64'({bus.DDRAM_RD, bus.DDRAM_WE}), 64'(0));
                tick();
            end
            bus.DDRAM_DOUT_READY = 1'b0;
        end
        bus.ch_req[win] = 1'b0;
        #1;
        chk("done_ack", 64'(bus.ch_ack), 64'(0));
        chk("done_rvalid", 64'(bus.ch_rvalid), 64'(0));
        chk("done_cmd", 64'({bus.DDRAM_RD, bus.DDRAM_WE}), 64'(0));
    endtask

    initial begin
        rst = 1'b1;
        bus.ch_req   = '0;
        bus.ch_we    = '0;
        bus.ch_addr  = '0;
        bus.ch_burst = '0;
        bus.ch_din   = '0;
        bus.ch_be    = '0;
        bus.DDRAM_BUSY       = 1'b0;
        bus.DDRAM_DOUT       = '0;
        bus.DDRAM_DOUT_READY = 1'b1;
        m_last = 3;
        for (int c = 0; c < 4; c++) begin
            m_we[c] = 1'b0; m_addr[c] = '0; m_burst[c] = '0; m_din[c] = '0; m_be[c] = '0;
        end
        tick();
        tick();
        chk("reset_cmd", 64'({bus.DDRAM_RD, bus.DDRAM_WE}), 64'(0));
        chk("reset_ack", 64'(bus.ch_ack), 64'(0));
        chk("reset_rvalid", 64'(bus.ch_rvalid), 64'(0));
        chk("reset_bcnt", 64'(bus.DDRAM_BURSTCNT), 64'(0));
        chk("reset_be", 64'(bus.DDRAM_BE), 64'(0));
        rst = 1'b0;
        bus.DDRAM_DOUT_READY = 1'b0;
        tick();

        // single write on ch2
        set_ch(2, 1'b1, 29'h123, 4'd1, 8'h0F);
        run_txn(0, 0, -1, w);
        // read burst of 4 on ch1 with gaps
        set_ch(1, 1'b0, 29'h0AB_CDEF, 4'd4, 8'h00);
        run_txn(0, 2, -1, w);
        // five busy cycles before acceptance
        set_ch(0, 1'b0, 29'h1555_0000, 4'd6, 8'h00);
        run_txn(5, 1, -1, w);
        // burst clamp edges on ch3
        set_ch(3, 1'b0, 29'h77, 4'd0, 8'h00);
        run_txn(0, 1, -1, w);
        set_ch(3, 1'b0, 29'h78, 4'd15, 8'h00);
        run_txn(1, 1, -1, w);
        // reset after two of eight beats, then normal service resumes from ch0
        set_ch(1, 1'b0, 29'h300, 4'd8, 8'h00);
        run_txn(0, 1, 2, w);
        set_ch(2, 1'b1, 29'h400, 4'd1, 8'hA5);
        set_ch(0, 1'b0, 29'h500, 4'd3, 8'h00);
        run_txn(0, 1, -1, w);
        chk("post_rst_first", 64'(issued_addr), 64'(29'h500));
        run_txn(2, 1, -1, w);

        // all four channels reading continuously from reset: order 0,1,2,3,0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last = 3;
        for (int c = 0; c < 4; c++) set_ch(c, 1'b0, 29'(29'h100 + c), 4'd2, 8'h00);
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 1, -1, w);
            chk("rr_order", 64'(issued_addr), 64'(29'h100 + (i % 4)));
            set_ch(w, 1'b0, 29'(29'h100 + w), 4'd2, 8'h00);
        end

        // random traffic
        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < 4; c++)
                if (!bus.ch_req[c] && $urandom_range(0, 1) == 1)
                    set_ch(c, 1'($urandom_range(0, 1)), 29'($urandom), 4'($urandom), 8'($urandom));
            if (bus.ch_req == 4'b0)
                set_ch($urandom_range(0, 3), 1'($urandom_range(0, 1)), 29'($urandom),
                       4'($urandom), 8'($urandom));
            run_txn($urandom_range(0, 2), 2, -1, w);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr_rr_arbiter.md
DDR_RR_ARBITER -- requirements
Module: ddr_rr_arbiter

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all logic rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port ch_req, input, 4 bits: per-channel request level, held high until ack.
REQ-004 SHALL have port ch_we, input, 4 bits: per-channel 1=write, 0=read; stable while req high.
REQ-005 SHALL have port ch_addr, input, 4x29 bits: per-channel 64-bit-word address.
REQ-006 SHALL have port ch_burst, input, 4x4 bits: per-channel read beat count 1..8.
REQ-007 SHALL have port ch_din, input, 4x64 bits: per-channel write data.
REQ-008 SHALL have port ch_be, input, 4x8 bits: per-channel write byte enables.
REQ-009 SHALL have port ch_ack, output, 4 bits: one-cycle completion pulse to the owner.
REQ-010 SHALL have port ch_rvalid, output, 4 bits: read beat valid to the owner.
REQ-011 SHALL have port rdata, output, 64 bits: shared read data, equal to DDRAM_DOUT.
REQ-012 SHALL have DDRAM ports DDRAM_BUSY in (1), DDRAM_DOUT in (64) and DDRAM_DOUT_READY in (1).
REQ-013 SHALL have DDRAM ports DDRAM_ADDR out (29), DDRAM_BURSTCNT out (8), DDRAM_DIN out (64), DDRAM_BE out (8), DDRAM_RD out (1) and DDRAM_WE out (1).

Function
REQ-014 SHALL implement the states IDLE, ISSUE and RDWAIT.
REQ-015 SHALL sample ch_req only in IDLE.
REQ-016 SHALL use round-robin pointer last (2 bits); winner = first requesting channel searching last+1, last+2, ... modulo 4.
REQ-017 SHALL, in IDLE with any req, latch the winner's addr, we, burst, din and be, set last=winner, assert DDRAM_RD or DDRAM_WE from the next edge, and enter ISSUE.
REQ-018 SHALL, in IDLE with no req, hold DDRAM_RD=DDRAM_WE=0 and leave last unchanged.
REQ-019 SHALL count a command as accepted in an ISSUE cycle with DDRAM_BUSY=0; while BUSY=1 it SHALL hold all command outputs stable.
REQ-020 SHALL drive writes with DDRAM_BURSTCNT=1, DDRAM_BE=latched be and DDRAM_DIN=latched din.
REQ-021 SHALL drive reads with DDRAM_BURSTCNT={4'b0,burst} and DDRAM_BE=8'hFF; a burst value of 0 SHALL be treated as 1 and a value above 8 as 8.
REQ-022 SHALL, on write acceptance, pulse ch_ack[owner] in that same cycle (combinational), drop DDRAM_WE at the edge and return to IDLE.
REQ-023 SHALL, on read acceptance, drop DDRAM_RD at the edge, clear the beat counter and enter RDWAIT.
REQ-024 SHALL, in RDWAIT, set ch_rvalid[owner]=DDRAM_DOUT_READY each cycle and increment the counter per beat.
REQ-025 SHALL, on the last beat, assert ch_ack[owner] in the same cycle as its ch_rvalid and return to IDLE.
REQ-026 SHALL keep ch_rvalid at 0 outside RDWAIT; DOUT_READY in IDLE/ISSUE SHALL be ignored.
REQ-027 SHALL require the requester to deassert req at the ack edge; the next IDLE cycle therefore sees post-ack req, so back-to-back throughput is one command per IDLE+ISSUE (min 2 cycles write).
REQ-028 SHALL keep at most one channel bit set in ch_ack and in ch_rvalid at any time.
REQ-029 SHALL, with simultaneous requests, grant each requesting channel once before any channel is granted twice.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, DDRAM_RD=DDRAM_WE=0, ch_ack=0, ch_rvalid=0, last=3 (ch0 first), beat counter=0, DDRAM_BURSTCNT=0 and DDRAM_BE=0.
REQ-031 SHALL, on reset mid-ISSUE or mid-RDWAIT, abandon the transaction with no ack; beats still returned by DDRAM after reset SHALL be discarded (IDLE ignores them).

Verification
REQ-032 SHALL verify single write: ch2 req we=1 addr=0x123 be=0x0F, BUSY=0 -> DDRAM_WE high 1 cycle, ADDR=0x123, BURSTCNT=1, BE=0x0F, ch_ack=4'b0100 same cycle.
REQ-033 SHALL verify read burst: ch1 read burst=4, DDRAM returns 4 beats with gaps -> 4 ch_rvalid[1] pulses, rdata matches, ch_ack[1] on the 4th beat only.
REQ-034 SHALL verify round-robin: all 4 channels request reads continuously after reset -> grant order 0,1,2,3,0.
REQ-035 SHALL verify busy stall: BUSY=1 for 5 cycles during ISSUE -> RD/ADDR/BURSTCNT stable for 5 cycles, accepted on the 6th, no early ack.
REQ-036 SHALL verify reset mid-read: rst after 2 of 8 beats -> no ack, outputs at reset values, the remaining 6 beats produce no ch_rvalid, and the next request is served normally.
REQ-037 SHALL verify burst edge: ch3 burst=0 -> BURSTCNT=1; burst=15 -> BURSTCNT=8, ack after 8 beats.
